// File: rtl/mux_rr_stream_pkg.sv
// mux_pkg: shared arbitration types and helpers for stream muxes/arbiters.
//   arb_mode_t : ARB_RR (round-robin from a rotating pointer) or
//                ARB_FIXED (lowest requesting index always wins)
//   idx_width  : width of a channel index for M channels (min 1)
package mux_pkg;

   typedef enum logic {
      ARB_RR    = 1'b0,
      ARB_FIXED = 1'b1
   } arb_mode_t;

   function automatic int idx_width(input int m);
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/mux_rr_stream_if.sv
// mux_rr_stream_if: M-channel input side plus single-channel output side of
// the registered stream mux.
//   in_valid/in_data/in_ready : per-channel producer handshake, data at [i*N +: N]
//   out_valid/out_data/out_sel/out_ready : consumer handshake plus winning index
//   slave  : the mux itself
//   master : the producers/consumer driving it
interface mux_rr_stream_if #(
   parameter int N = 16,
   parameter int M = 16
) ();
   localparam int S = mux_pkg::idx_width(M);

   logic [M-1:0]   in_valid;
   logic [M*N-1:0] in_data;
   logic [M-1:0]   in_ready;
   logic           out_valid;
   logic [N-1:0]   out_data;
   logic [S-1:0]   out_sel;
   logic           out_ready;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sel
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sel
   );
endinterface

// File: rtl/mux_rr_stream_rr_arbiter.sv
// rr_arbiter: purely combinational M-way arbiter.
//   req   : request vector
//   ptr   : round-robin start index (ignored in ARB_FIXED)
//   mode  : ARB_RR or ARB_FIXED
//   grant : index of winning request (0 when none)
//   any   : at least one request present
module rr_arbiter
   import mux_pkg::*;
#(
   parameter int M = 16,
   localparam int S = idx_width(M)
) (
   input  logic [M-1:0] req,
   input  logic [S-1:0] ptr,
   input  arb_mode_t    mode,
   output logic [S-1:0] grant,
   output logic         any
);

   logic [S-1:0] base;
   logic [S:0]   idx;

   assign any  = |req;
   assign base = (mode == ARB_FIXED) ? '0 : ptr;

   // Rotate-scan from base. Walking the offsets downward lets the closest
   // requester to base overwrite any farther one. The extra index bit keeps
   // base+k from overflowing before the modulo-M wrap, so non-power-of-two M
   // wraps correctly.
   always_comb begin
      grant = '0;
      idx   = '0;
      for (int k = M-1; k >= 0; k--) begin
         idx = {1'b0, base} + (S+1)'(k);
         if (idx >= (S+1)'(M)) idx = idx - (S+1)'(M);
         if (req[idx[S-1:0]]) grant = idx[S-1:0];
      end
   end

endmodule

// File: rtl/mux_rr_stream.sv
// mux_rr_stream: registered M-channel, N-bit stream mux with arbitration.
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset; also gates in_ready low
//   bus  : mux_rr_stream_if.slave (per-channel inputs, one output register)
// Each cycle the register can load (empty or draining), one requesting
// channel is granted, its word is captured along with its index.
module mux_rr_stream
   import mux_pkg::*;
#(
   parameter int        N    = 16,
   parameter int        M    = 16,
   parameter arb_mode_t MODE = ARB_RR,
   localparam int       S    = idx_width(M)
) (
   input  logic            clk,
   input  logic            rst,
   mux_rr_stream_if.slave  bus
);

   logic [S-1:0] grant;
   logic [S-1:0] ptr_q;
   logic         any;
   logic         load;
   logic [M-1:0] rdy;
   logic [N-1:0] sel_data;

   logic         vld_q;
   logic [N-1:0] data_q;
   logic [S-1:0] sel_q;

   rr_arbiter #(.M(M)) u_arb (
      .req   (bus.in_valid),
      .ptr   (ptr_q),
      .mode  (MODE),
      .grant (grant),
      .any   (any)
   );

   // Register is free when empty or being drained this very cycle, which
   // allows fill and drain on the same edge (no bubble).
   assign load     = ~vld_q | bus.out_ready;
   assign sel_data = bus.in_data[int'(grant)*N +: N];

   always_comb begin
      rdy = '0;
      if (load && any && !rst) rdy[grant] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q  <= 1'b0;
         data_q <= '0;
         sel_q  <= '0;
         ptr_q  <= '0;
      end else if (load) begin
         if (any) begin
            vld_q  <= 1'b1;
            data_q <= sel_data;
            sel_q  <= grant;
            // Pointer moves just past the winner; FIXED leaves it at 0.
            if (MODE == ARB_RR)
               ptr_q <= (grant == S'(M-1)) ? '0 : grant + S'(1);
         end else begin
            vld_q <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = rdy;
   assign bus.out_valid = vld_q;
   assign bus.out_data  = data_q;
   assign bus.out_sel   = sel_q;

endmodule

// File: tb/tb_mux_rr_stream.sv
// Bench: RR and FIXED instances share one stimulus stream; each is checked
// against a queue-free reference model computed from the arbitration rules.
module tb_mux_rr_stream;
   import mux_pkg::*;

   localparam int N = 16;
   localparam int M = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [M-1:0]   t_valid = '0;
   logic [M*N-1:0] t_data  = '0;
   logic           t_ordy  = 1'b0;
   logic           t_rst   = 1'b1;

   int compared   = 0;
   int mismatched = 0;
   bit chk_en     = 0;

   mux_rr_stream_if #(.N(N), .M(M)) bus_rr ();
   mux_rr_stream_if #(.N(N), .M(M)) bus_fx ();

   assign bus_rr.in_valid  = t_valid;
   assign bus_rr.in_data   = t_data;
   assign bus_rr.out_ready = t_ordy;
   assign bus_fx.in_valid  = t_valid;
   assign bus_fx.in_data   = t_data;
   assign bus_fx.out_ready = t_ordy;

   mux_rr_stream #(.N(N), .M(M), .MODE(ARB_RR)) dut_rr (
      .clk (clk), .rst (t_rst), .bus (bus_rr));
   mux_rr_stream #(.N(N), .M(M), .MODE(ARB_FIXED)) dut_fx (
      .clk (clk), .rst (t_rst), .bus (bus_fx));

   // index 0 = RR instance, 1 = FIXED instance
   logic         o_vld [2];
   logic [N-1:0] o_data[2];
   logic [2:0]   o_sel [2];
   logic [M-1:0] o_rdy [2];
   assign o_vld[0] = bus_rr.out_valid;  assign o_vld[1] = bus_fx.out_valid;
   assign o_data[0] = bus_rr.out_data;  assign o_data[1] = bus_fx.out_data;
   assign o_sel[0] = bus_rr.out_sel;    assign o_sel[1] = bus_fx.out_sel;
   assign o_rdy[0] = bus_rr.in_ready;   assign o_rdy[1] = bus_fx.in_ready;

   // Reference model state
   bit           e_vld [2];
   logic [N-1:0] e_data[2];
   int           e_sel [2];
   int           e_ptr [2];

   function automatic int model_grant(input int m);
      int start = (m == 0) ? e_ptr[m] : 0;
      for (int k = 0; k < M; k++)
         if (t_valid[(start + k) % M]) return (start + k) % M;
      return -1;
   endfunction

   function automatic logic [M-1:0] exp_rdy(input int m);
      int g = model_grant(m);
      logic [M-1:0] r = '0;
      if (!t_rst && (!e_vld[m] || t_ordy) && g >= 0) r[g] = 1'b1;
      return r;
   endfunction

   task automatic drive(input logic [M-1:0] v, input logic [M*N-1:0] d,
                        input logic o, input logic r);
      @(negedge clk);
      t_valid = v; t_data = d; t_ordy = o; t_rst = r;
      #1;
   endtask

   // Advance one clock edge and the model with it.
   task automatic tick();
      int g;
      @(posedge clk);
      for (int m = 0; m < 2; m++) begin
         g = model_grant(m);
         if (t_rst) begin
            e_vld[m] = 0; e_data[m] = '0; e_sel[m] = 0; e_ptr[m] = 0;
         end else if (!e_vld[m] || t_ordy) begin
            if (g >= 0) begin
               e_vld[m] = 1; e_data[m] = t_data[g*N +: N]; e_sel[m] = g;
               if (m == 0) e_ptr[m] = (g + 1) % M;
            end else e_vld[m] = 0;
         end
      end
      #1;
   endtask

   function automatic logic [M*N-1:0] seq_data();
      logic [M*N-1:0] d;
      for (int i = 0; i < M; i++) d[i*N +: N] = 16'hA000 + 16'(i);
      return d;
   endfunction

   // Running checks: one-hot in_ready, output held stable across a stall.
   bit           p_stall[2];
   logic [N-1:0] p_data [2];
   logic [2:0]   p_sel  [2];
   always @(negedge clk) begin
      #3;
      if (chk_en) begin
         for (int m = 0; m < 2; m++) begin
            compared++;
            if (!$onehot0(o_rdy[m])) begin
               mismatched++;
               $display("FAIL onehot0[%0d] in_ready=%b", m, o_rdy[m]);
            end
            if (p_stall[m]) begin
               compared++;
               if (o_vld[m] !== 1'b1 || o_data[m] !== p_data[m] || o_sel[m] !== p_sel[m]) begin
                  mismatched++;
                  $display("FAIL stall_hold[%0d] got v%b %h/%0d want v1 %h/%0d",
                           m, o_vld[m], o_data[m], o_sel[m], p_data[m], p_sel[m]);
               end
            end
            p_stall[m] = (o_vld[m] === 1'b1) && !t_ordy && !t_rst;
            p_data[m]  = o_data[m];
            p_sel[m]   = o_sel[m];
         end
      end
   end

   task automatic test_reset();
      drive('1, seq_data(), 1'b1, 1'b1);
      for (int m = 0; m < 2; m++) begin
         compared++;
         if (o_rdy[m] !== '0) begin
            mismatched++;
            $display("FAIL reset_rdy[%0d] got %b want 00000", m, o_rdy[m]);
         end
      end
      tick();
      drive('0, seq_data(), 1'b1, 1'b0);
      tick();
      chk_en = 1;
      for (int m = 0; m < 2; m++) begin
         compared++;
         if (o_vld[m] !== 1'b0 || o_sel[m] !== 3'd0 || o_data[m] !== 16'h0) begin
            mismatched++;
            $display("FAIL reset_out[%0d] got v%b %h/%0d want v0 0000/0",
                     m, o_vld[m], o_data[m], o_sel[m]);
         end
      end
   endtask

   task automatic test_rr_fairness();
      for (int c = 0; c < 6; c++) begin
         drive('1, seq_data(), 1'b1, 1'b0);
         for (int m = 0; m < 2; m++) begin
            compared++;
            if (o_rdy[m] !== exp_rdy(m)) begin
               mismatched++;
               $display("FAIL fair_rdy[%0d] c%0d got %b want %b", m, c, o_rdy[m], exp_rdy(m));
            end
         end
         tick();
         compared++;
         if (o_vld[0] !== 1'b1 || o_sel[0] !== 3'(c % M) || o_data[0] !== 16'hA000 + 16'(c % M)) begin
            mismatched++;
            $display("FAIL fair_rr c%0d got v%b %h/%0d want v1 %h/%0d",
                     c, o_vld[0], o_data[0], o_sel[0], 16'hA000 + 16'(c % M), c % M);
         end
         compared++;
         if (o_vld[1] !== 1'b1 || o_sel[1] !== 3'd0 || o_data[1] !== 16'hA000) begin
            mismatched++;
            $display("FAIL fair_fx c%0d got v%b %h/%0d want v1 a000/0", c, o_vld[1], o_data[1], o_sel[1]);
         end
      end
   endtask

   task automatic test_wrap_skip();
      logic [M-1:0] vs [5] = '{5'b01000, 5'b00011, 5'b00011, 5'b10100, 5'b10100};
      int           rr [5] = '{3, 0, 1, 2, 4};
      for (int c = 0; c < 5; c++) begin
         drive(vs[c], seq_data(), 1'b1, 1'b0);
         for (int m = 0; m < 2; m++) begin
            compared++;
            if (o_rdy[m] !== exp_rdy(m)) begin
               mismatched++;
               $display("FAIL wrap_rdy[%0d] c%0d got %b want %b", m, c, o_rdy[m], exp_rdy(m));
            end
         end
         tick();
         compared++;
         if (o_sel[0] !== 3'(rr[c]) || o_sel[0] !== 3'(e_sel[0])) begin
            mismatched++;
            $display("FAIL wrap_rr c%0d got %0d want %0d", c, o_sel[0], rr[c]);
         end
         compared++;
         if (o_sel[1] !== 3'(e_sel[1]) || (c >= 3 && o_sel[1] !== 3'd2)) begin
            mismatched++;
            $display("FAIL wrap_fx c%0d got %0d want %0d", c, o_sel[1], e_sel[1]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [M*N-1:0] d = seq_data();
      d[2*N +: N] = 16'h1234;
      drive(5'b00100, d, 1'b1, 1'b0);
      tick();
      for (int c = 0; c < 4; c++) begin
         drive('1, d, (c == 3), 1'b0);
         for (int m = 0; m < 2; m++) begin
            compared++;
            if (o_rdy[m] !== exp_rdy(m) || (c < 3 && o_rdy[m] !== '0)) begin
               mismatched++;
               $display("FAIL bp_rdy[%0d] c%0d got %b want %b", m, c, o_rdy[m], exp_rdy(m));
            end
            compared++;
            if (o_vld[m] !== 1'b1 || o_sel[m] !== 3'd2 || o_data[m] !== 16'h1234) begin
               mismatched++;
               $display("FAIL bp_hold[%0d] c%0d got v%b %h/%0d want v1 1234/2",
                        m, c, o_vld[m], o_data[m], o_sel[m]);
            end
         end
         tick();
      end
      compared++;
      if (o_sel[0] !== 3'd3 || o_data[0] !== d[3*N +: N]) begin
         mismatched++;
         $display("FAIL bp_next_rr got %h/%0d want %h/3", o_data[0], o_sel[0], d[3*N +: N]);
      end
      compared++;
      if (o_sel[1] !== 3'(e_sel[1]) || o_data[1] !== e_data[1]) begin
         mismatched++;
         $display("FAIL bp_next_fx got %h/%0d want %h/%0d", o_data[1], o_sel[1], e_data[1], e_sel[1]);
      end
   endtask

   task automatic test_empty();
      drive('0, seq_data(), 1'b1, 1'b0);
      tick();
      for (int m = 0; m < 2; m++) begin
         compared++;
         if (o_vld[m] !== 1'b0) begin
            mismatched++;
            $display("FAIL empty_vld[%0d] got %b want 0", m, o_vld[m]);
         end
      end
      drive(5'b01000, seq_data(), 1'b1, 1'b0);
      tick();
      for (int m = 0; m < 2; m++) begin
         compared++;
         if (o_vld[m] !== 1'b1 || o_sel[m] !== 3'd3 || o_data[m] !== 16'hA003) begin
            mismatched++;
            $display("FAIL empty_refill[%0d] got v%b %h/%0d want v1 a003/3",
                     m, o_vld[m], o_data[m], o_sel[m]);
         end
      end
   endtask

   task automatic test_reset_stall();
      drive('1, seq_data(), 1'b0, 1'b0);
      tick();
      drive('1, seq_data(), 1'b0, 1'b1);
      for (int m = 0; m < 2; m++) begin
         compared++;
         if (o_rdy[m] !== '0) begin
            mismatched++;
            $display("FAIL rststall_rdy[%0d] got %b want 00000", m, o_rdy[m]);
         end
      end
      tick();
      for (int m = 0; m < 2; m++) begin
         compared++;
         if (o_vld[m] !== 1'b0) begin
            mismatched++;
            $display("FAIL rststall_vld[%0d] got %b want 0", m, o_vld[m]);
         end
      end
      drive('1, seq_data(), 1'b1, 1'b0);
      tick();
      compared++;
      if (o_sel[0] !== 3'd0 || o_vld[0] !== 1'b1) begin
         mismatched++;
         $display("FAIL rststall_ptr got v%b sel %0d want v1 sel 0", o_vld[0], o_sel[0]);
      end
   endtask

   task automatic test_random();
      logic [M*N-1:0] d;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < M; i++) d[i*N +: N] = 16'($urandom);
         drive(5'($urandom), d, ($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0));
         for (int m = 0; m < 2; m++) begin
            compared++;
            if (o_rdy[m] !== exp_rdy(m)) begin
               mismatched++;
               $display("FAIL rand_rdy[%0d] c%0d got %b want %b", m, c, o_rdy[m], exp_rdy(m));
            end
         end
         tick();
         for (int m = 0; m < 2; m++) begin
            compared++;
            if (o_vld[m] !== e_vld[m] || o_sel[m] !== 3'(e_sel[m]) || o_data[m] !== e_data[m]) begin
               mismatched++;
               $display("FAIL rand_out[%0d] c%0d got v%b %h/%0d want v%b %h/%0d",
                        m, c, o_vld[m], o_data[m], o_sel[m], e_vld[m], e_data[m], e_sel[m]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_rr_fairness();
      test_wrap_skip();
      test_backpressure();
      test_empty();
      test_reset_stall();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
